multiplier_arbiter: RTL and testbench
=====================================

Name: multiplier_arbiter

Overview:
- Sequences and shares one four_bit_multiplier instance between two requesters.
- Arbitrates incoming operand pairs round-robin and drives the multiplier operands and enable.
- Waits a configurable settle time, then captures the 8-bit product into a per-requester result register.
- Holds the result until the owning requester acknowledges it.
- One operation is in flight at a time.

Parameters:
- MUL_LATENCY, 1: cycles the multiplier is enabled before the product is captured. Legal range is 1 to 4; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_a  input  4  requester 0 multiplicand (bit 3 = A3).
- req0_b  input  4  requester 0 multiplier (bit 3 = B3).
- req0_ready  output  1  combinational; request 0 accepted this cycle.
- res0_valid  output  1  requester 0 result available.
- res0_y  output  8  requester 0 product (bit 7 = Y7).
- res0_ack  input  1  requester 0 consumes its result.
- req1_valid, req1_a, req1_b, req1_ready, res1_valid, res1_y, res1_ack: identical definitions for requester 1.
- mul_a  output  4  registered operand to multiplier A3..A0.
- mul_b  output  4  registered operand to multiplier B3..B0.
- mul_enable  output  1  registered; drives multiplier enable.
- mul_y  input  8  multiplier Y7..Y0.
- busy  output  1  high whenever the state is not IDLE.
- op_count  output  8  completed-operation counter; wraps 255 -> 0.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert assumed at system level):
  - State goes to IDLE.
  - mul_a = 0, mul_b = 0, mul_enable = 0.
  - res0_valid = res1_valid = 0; res0_y = res1_y = 0.
  - op_count = 0; busy = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Reset mid-operation discards the operation. No result is produced and op_count is not incremented.
- IDLE:
  - Grant is given only in IDLE.
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready is high only in the IDLE cycle where N is granted; otherwise 0. A handshake is valid & ready.
  - On handshake: mul_a <= reqN_a, mul_b <= reqN_b, mul_enable <= 1, grant id latched, cnt <= MUL_LATENCY-1, go to EXEC.
  - If no valid, stay in IDLE.
- EXEC:
  - mul_enable = 1 and the operands are held stable.
  - If cnt != 0, decrement cnt.
  - If cnt == 0:
    - Capture mul_y into resG_y and set resG_valid, where G is the granted requester.
    - mul_enable <= 0, mul_a <= 0, mul_b <= 0.
    - Go to DONE.
  - New requests are not accepted; reqN_ready = 0.
- DONE:
  - Wait for resG_ack with resG_valid = 1.
  - On ack: clear resG_valid, last_grant <= G, op_count increments (wrapping), go to IDLE.
  - resG_y retains its value after ack until overwritten by the next capture for that requester.
  - Ack from the non-granted requester is ignored.
  - resN_ack while resN_valid = 0 is ignored in any state.
- Timing (handshake in cycle T):
  - mul_enable high in cycles T+1 .. T+MUL_LATENCY.
  - resG_valid first visible in cycle T+MUL_LATENCY+1.
  - Ack in that same cycle returns to IDLE at T+MUL_LATENCY+2.
  - Minimum issue interval is MUL_LATENCY+2 cycles.
- Arithmetic: the product is unsigned 4x4 -> 8 bits, taken straight from mul_y; no truncation.
- Requests whose valid is held while the other requester is served remain pending. Round-robin guarantees service within one operation.
- Valid dropped before the handshake is legal; nothing is issued for it.

Test Plan:
- Reset, then req0: valid, a=15, b=15, MUL_LATENCY=1 -> req0_ready high in the handshake cycle T; mul_enable high in T+1 only; res0_valid in T+2 with res0_y=0xE1; ack -> op_count=1.
- Both valid in the same cycle after reset (req0 3x5, req1 7x9), acks returned immediately -> req0 served first with res0_y=0x0F; req1 served next with res1_y=0x3F; a third simultaneous pair is granted to req0 (alternation).
- MUL_LATENCY=3, req1 a=12, b=10 -> mul_enable high exactly 3 cycles; res1_valid at T+4 with res1_y=0x78; mul_a and mul_b return to 0 after capture.
- Withhold res0_ack for 10 cycles while req1_valid is held -> busy stays 1, req1_ready stays 0, res0_y stable; res1_ack toggling is ignored; after res0_ack, req1 is granted on the next IDLE cycle.
- Assert rst_n low during EXEC -> all outputs return to reset values immediately (asynchronously); after release, no res_valid is produced and op_count=0.
- 256 back-to-back ops with a=1, b=0..15 cycling -> each res_y equals b; op_count wraps to 0 after the 256th ack.

Source files
------------

// File: rtl/multiplier_arbiter.sv
// Round-robin sharing of one external 4x4 multiplier between two requesters.
// One operation in flight; each result is held per requester until acknowledged.
module multiplier_arbiter #(
  parameter int MUL_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  output logic       res0_valid,
  output logic [7:0] res0_y,
  input  logic       res0_ack,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res1_valid,
  output logic [7:0] res1_y,
  input  logic       res1_ack,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  output logic       mul_enable,
  input  logic [7:0] mul_y,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(MUL_LATENCY - 1);

  state_t     state_r, state_nxt_s;
  logic [3:0] mul_a_r, mul_a_nxt_s;
  logic [3:0] mul_b_r, mul_b_nxt_s;
  logic       mul_enable_r, mul_enable_nxt_s;
  logic       res0_valid_r, res0_valid_nxt_s;
  logic [7:0] res0_y_r, res0_y_nxt_s;
  logic       res1_valid_r, res1_valid_nxt_s;
  logic [7:0] res1_y_r, res1_y_nxt_s;
  logic [7:0] op_count_r, op_count_nxt_s;
  logic       last_grant_r, last_grant_nxt_s;
  logic       grant_id_r, grant_id_nxt_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       grant0_s, grant1_s;

  // On a tie the requester that was not served last wins.
  assign grant0_s = req0_valid & (~req1_valid | last_grant_r);
  assign grant1_s = req1_valid & (~req0_valid | ~last_grant_r);

  assign req0_ready = (state_r == IDLE) & grant0_s;
  assign req1_ready = (state_r == IDLE) & grant1_s;
  assign mul_a      = mul_a_r;
  assign mul_b      = mul_b_r;
  assign mul_enable = mul_enable_r;
  assign res0_valid = res0_valid_r;
  assign res0_y     = res0_y_r;
  assign res1_valid = res1_valid_r;
  assign res1_y     = res1_y_r;
  assign op_count   = op_count_r;
  assign busy       = busy_r;

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt_s      = state_r;
    mul_a_nxt_s      = mul_a_r;
    mul_b_nxt_s      = mul_b_r;
    mul_enable_nxt_s = mul_enable_r;
    res0_valid_nxt_s = res0_valid_r;
    res0_y_nxt_s     = res0_y_r;
    res1_valid_nxt_s = res1_valid_r;
    res1_y_nxt_s     = res1_y_r;
    op_count_nxt_s   = op_count_r;
    last_grant_nxt_s = last_grant_r;
    grant_id_nxt_s   = grant_id_r;
    cnt_nxt_s        = cnt_r;
    case (state_r)
      IDLE: begin
        if (grant0_s) begin
          mul_a_nxt_s      = req0_a;
          mul_b_nxt_s      = req0_b;
          mul_enable_nxt_s = 1'b1;
          grant_id_nxt_s   = 1'b0;
          cnt_nxt_s        = CNT_INIT;
          state_nxt_s      = EXEC;
        end else if (grant1_s) begin
          mul_a_nxt_s      = req1_a;
          mul_b_nxt_s      = req1_b;
          mul_enable_nxt_s = 1'b1;
          grant_id_nxt_s   = 1'b1;
          cnt_nxt_s        = CNT_INIT;
          state_nxt_s      = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r != 2'd0) begin
          cnt_nxt_s = cnt_r - 2'd1;
        end else begin
          if (grant_id_r == 1'b0) begin
            res0_y_nxt_s     = mul_y;
            res0_valid_nxt_s = 1'b1;
          end else begin
            res1_y_nxt_s     = mul_y;
            res1_valid_nxt_s = 1'b1;
          end
          mul_enable_nxt_s = 1'b0;
          mul_a_nxt_s      = 4'd0;
          mul_b_nxt_s      = 4'd0;
          state_nxt_s      = DONE;
        end
      end
      DONE: begin
        // Only the owner's ack, while its result is pending, closes the operation.
        if ((grant_id_r == 1'b0) && res0_ack && res0_valid_r) begin
          res0_valid_nxt_s = 1'b0;
          last_grant_nxt_s = 1'b0;
          op_count_nxt_s   = op_count_r + 8'd1;
          state_nxt_s      = IDLE;
        end else if ((grant_id_r == 1'b1) && res1_ack && res1_valid_r) begin
          res1_valid_nxt_s = 1'b0;
          last_grant_nxt_s = 1'b1;
          op_count_nxt_s   = op_count_r + 8'd1;
          state_nxt_s      = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      mul_a_r      <= 4'd0;
      mul_b_r      <= 4'd0;
      mul_enable_r <= 1'b0;
      res0_valid_r <= 1'b0;
      res0_y_r     <= 8'd0;
      res1_valid_r <= 1'b0;
      res1_y_r     <= 8'd0;
      op_count_r   <= 8'd0;
      last_grant_r <= 1'b1;
      grant_id_r   <= 1'b0;
      cnt_r        <= 2'd0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mul_a_r      <= mul_a_nxt_s;
      mul_b_r      <= mul_b_nxt_s;
      mul_enable_r <= mul_enable_nxt_s;
      res0_valid_r <= res0_valid_nxt_s;
      res0_y_r     <= res0_y_nxt_s;
      res1_valid_r <= res1_valid_nxt_s;
      res1_y_r     <= res1_y_nxt_s;
      op_count_r   <= op_count_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      grant_id_r   <= grant_id_nxt_s;
      cnt_r        <= cnt_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter: one instance at latency 1, one at latency 3,
// each paired with a behavioural 4x4 unsigned multiplier.
module tb_multiplier_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid, res0_ack, res1_ack;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, res0_valid, res1_valid;
  logic [7:0] res0_y, res1_y;
  logic [3:0] mul_a, mul_b;
  logic       mul_enable, busy;
  logic [7:0] mul_y, op_count;

  logic       q0v3, q1v3, a0k3, a1k3;
  logic [3:0] q0a3, q0b3, q1a3, q1b3;
  logic       q0r3, q1r3, r0v3, r1v3;
  logic [7:0] r0y3, r1y3;
  logic [3:0] ma3, mb3;
  logic       me3, busy3;
  logic [7:0] my3, opc3;

  int n_cmp;
  int n_err;

  assign mul_y = {4'd0, mul_a} * {4'd0, mul_b};
  assign my3   = {4'd0, ma3} * {4'd0, mb3};

  multiplier_arbiter #(.MUL_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .res0_valid(res0_valid), .res0_y(res0_y), .res0_ack(res0_ack),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res1_valid(res1_valid), .res1_y(res1_y), .res1_ack(res1_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable), .mul_y(mul_y),
    .busy(busy), .op_count(op_count)
  );

  multiplier_arbiter #(.MUL_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q0v3), .req0_a(q0a3), .req0_b(q0b3), .req0_ready(q0r3),
    .res0_valid(r0v3), .res0_y(r0y3), .res0_ack(a0k3),
    .req1_valid(q1v3), .req1_a(q1a3), .req1_b(q1b3), .req1_ready(q1r3),
    .res1_valid(r1v3), .res1_y(r1y3), .res1_ack(a1k3),
    .mul_a(ma3), .mul_b(mb3), .mul_enable(me3), .mul_y(my3),
    .busy(busy3), .op_count(opc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp = n_cmp + 1;
    if (obs !== exp_v) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Full operation on the latency-1 instance for requester r; checks the product.
  task automatic run_op(input bit r, input logic [3:0] a, input logic [3:0] b);
    bit got;
    got = 1'b0;
    if (r == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if ((r == 1'b0 && req0_ready) || (r == 1'b1 && req1_ready)) begin
        got = 1'b1;
      end else begin
        tick();
      end
    end
    chk("handshake_timeout", {31'd0, got}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    if (r == 1'b0) begin
      chk("op_res0_y", {24'd0, res0_y}, {24'd0, {4'd0, a} * {4'd0, b}});
      res0_ack = 1'b1;
    end else begin
      chk("op_res1_y", {24'd0, res1_y}, {24'd0, {4'd0, a} * {4'd0, b}});
      res1_ack = 1'b1;
    end
    tick();
    res0_ack = 1'b0;
    res1_ack = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    {req0_valid, req1_valid, res0_ack, res1_ack} = 4'd0;
    {req0_a, req0_b, req1_a, req1_b} = 16'd0;
    {q0v3, q1v3, a0k3, a1k3} = 4'd0;
    {q0a3, q0b3, q1a3, q1b3} = 16'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mul_en", {31'd0, mul_enable}, 32'd0);
    chk("rst_mul_ab", {24'd0, mul_a, mul_b}, 32'd0);
    chk("rst_res_valid", {30'd0, res0_valid, res1_valid}, 32'd0);
    chk("rst_res_y", {16'd0, res0_y, res1_y}, 32'd0);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single op, 15x15, latency 1
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15;
    #1;
    chk("t1_ready_T", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("t1_en_T1", {31'd0, mul_enable}, 32'd1);
    chk("t1_mul_ab_T1", {24'd0, mul_a, mul_b}, 32'h0000_00FF);
    chk("t1_busy_T1", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_en_T2", {31'd0, mul_enable}, 32'd0);
    chk("t1_valid_T2", {31'd0, res0_valid}, 32'd1);
    chk("t1_y", {24'd0, res0_y}, 32'h0000_00E1);
    res0_ack = 1'b1;
    tick();
    res0_ack = 1'b0;
    chk("t1_valid_after_ack", {31'd0, res0_valid}, 32'd0);
    chk("t1_op_count", {24'd0, op_count}, 32'd1);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    chk("t1_y_retained", {24'd0, res0_y}, 32'h0000_00E1);

    // Latency 3 instance, req1 12x10
    q1v3 = 1'b1; q1a3 = 4'd12; q1b3 = 4'd10;
    #1;
    chk("t3_ready_T", {31'd0, q1r3}, 32'd1);
    tick();
    q1v3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("t3_en_high", {31'd0, me3}, 32'd1);
      chk("t3_mul_a_held", {28'd0, ma3}, 32'd12);
      chk("t3_no_valid_yet", {31'd0, r1v3}, 32'd0);
      tick();
    end
    chk("t3_en_low", {31'd0, me3}, 32'd0);
    chk("t3_valid_T4", {31'd0, r1v3}, 32'd1);
    chk("t3_y", {24'd0, r1y3}, 32'h0000_0078);
    chk("t3_mul_ab_cleared", {24'd0, ma3, mb3}, 32'd0);
    a1k3 = 1'b1;
    tick();
    a1k3 = 1'b0;
    chk("t3_op_count", {24'd0, opc3}, 32'd1);

    // Simultaneous requests after reset: req0 first, then req1, then req0 again
    do_reset();
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
    #1;
    chk("t2_tie_r0_ready", {31'd0, req0_ready}, 32'd1);
    chk("t2_tie_r1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("t2_exec_r1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("t2_res0_y", {24'd0, res0_y}, 32'h0000_000F);
    res0_ack = 1'b1;
    tick();
    res0_ack = 1'b0;
    chk("t2_r1_granted", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t2_res1_valid", {31'd0, res1_valid}, 32'd1);
    chk("t2_res1_y", {24'd0, res1_y}, 32'h0000_003F);
    res1_ack = 1'b1;
    tick();
    res1_ack = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd2;
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    #1;
    chk("t2_alt_r0_ready", {31'd0, req0_ready}, 32'd1);
    chk("t2_alt_r1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("t2_alt_y", {24'd0, res0_y}, 32'd4);
    res0_ack = 1'b1;
    tick();
    res0_ack = 1'b0;

    // Withheld ack with req1 pending; stray res1_ack ignored
    req0_valid = 1'b1; req0_a = 4'd6; req0_b = 4'd7;
    #1;
    chk("t4_r0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd4; req1_b = 4'd4;
    tick();
    for (int k = 0; k < 10; k++) begin
      res1_ack = ~res1_ack;
      #1;
      chk("t4_busy", {31'd0, busy}, 32'd1);
      chk("t4_r1_ready", {31'd0, req1_ready}, 32'd0);
      chk("t4_res0_y", {24'd0, res0_y}, 32'h0000_002A);
      chk("t4_res1_valid", {31'd0, res1_valid}, 32'd0);
      tick();
    end
    res1_ack = 1'b0;
    chk("t4_res0_still_valid", {31'd0, res0_valid}, 32'd1);
    res0_ack = 1'b1;
    tick();
    res0_ack = 1'b0;
    #1;
    chk("t4_r1_granted", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t4_res1_y", {24'd0, res1_y}, 32'h0000_0010);
    res1_ack = 1'b1;
    tick();
    res1_ack = 1'b0;
    chk("t4_op_count", {24'd0, op_count}, 32'd5);

    // Reset during EXEC
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9;
    tick();
    req0_valid = 1'b0;
    chk("t5_in_exec", {31'd0, mul_enable}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_en", {31'd0, mul_enable}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_mul_ab", {24'd0, mul_a, mul_b}, 32'd0);
    chk("t5_async_op_count", {24'd0, op_count}, 32'd0);
    chk("t5_async_res_y", {16'd0, res0_y, res1_y}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_no_result", {30'd0, res0_valid, res1_valid}, 32'd0);
    end
    chk("t5_op_count", {24'd0, op_count}, 32'd0);

    // 256 back-to-back ops, op_count wraps
    for (int i = 0; i < 256; i++) begin
      run_op(i[0], 4'd1, i[3:0]);
      if (i == 254) begin
        chk("t6_count_255", {24'd0, op_count}, 32'd255);
      end
    end
    chk("t6_count_wrap", {24'd0, op_count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
